// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// the fetch word width and helpers that derive the address field widths.
package icache_dm_pkg;

    // Instruction / address width shared with the fetch stage
    localparam int ILEN = 16;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REFILL  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Word-offset width within a line
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index width
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: the 15-bit word address minus offset and index fields
    function automatic int tag_w(input int lines, input int line_words);
        return (ILEN - 1) - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// Tag + valid storage for the cache: asynchronous read, synchronous write,
// single-cycle bulk invalidate. Valid bits reset; tags do not.
module icache_tag_ram
    import icache_dm_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_valid_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             clr_i
);

    logic [TAG_W-1:0] tag_mem [LINES];
    logic [LINES-1:0] valid_reg;
    logic [LINES-1:0] valid_next;

    // Per-line valid update: an installing write beats a simultaneous clear,
    // so a line refilled during a flush still lands valid
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_next[gi] = (wr_en_i && (wr_idx_i == IDX_W'(gi))) ? 1'b1 :
                                    clr_i                                 ? 1'b0 :
                                                                            valid_reg[gi];
        end
    endgenerate

    // Valid bit register with asynchronous clear on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Tag array write port (no reset; guarded by valid bits)
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_valid_o = valid_reg[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer next cycle; a miss
// refills the whole line word 0 first, then replays the requested word.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            icache_rd_i,
    input  logic [ILEN-1:0] icache_pc_i,
    output logic            icache_valid_o,
    output logic [ILEN-1:0] icache_instr_o,
    input  logic            flush_i,
    output logic            mem_rd_o,
    output logic [ILEN-1:0] mem_addr_o,
    input  logic            mem_valid_i,
    input  logic [ILEN-1:0] mem_data_i
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, LINE_WORDS);
    localparam int WA_W  = ILEN - 1;

    logic [1:0]       state_reg;
    logic [OFF_W-1:0] cnt_reg;
    logic [WA_W-1:0]  pc_reg;
    logic             valid_reg;
    logic [ILEN-1:0]  instr_reg;
    logic [ILEN-1:0]  crit_reg;

    logic [ILEN-1:0]  data_mem [LINES*LINE_WORDS];

    logic [WA_W-1:0]  req_wa;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] ref_idx;
    logic [TAG_W-1:0] ref_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             refill_beat;
    logic             refill_last;
    logic             unused_pc_bit;

    assign req_wa        = icache_pc_i[ILEN-1:1];
    assign req_idx       = req_wa[OFF_W +: IDX_W];
    assign req_tag       = req_wa[WA_W-1 -: TAG_W];
    assign ref_idx       = pc_reg[OFF_W +: IDX_W];
    assign ref_tag       = pc_reg[WA_W-1 -: TAG_W];
    assign unused_pc_bit = icache_pc_i[0];

    // A flush in the same cycle as a request forces that request to miss
    assign hit = (state_reg == ST_IDLE) && icache_rd_i && !flush_i &&
                 rd_valid && (rd_tag == req_tag);

    assign refill_beat = (state_reg == ST_REFILL) && mem_valid_i;
    assign refill_last = refill_beat && (cnt_reg == '1);

    assign mem_rd_o   = (state_reg == ST_REFILL);
    assign mem_addr_o = mem_rd_o ? {pc_reg[WA_W-1:OFF_W], cnt_reg, 1'b0} : '0;

    assign icache_valid_o = valid_reg;
    assign icache_instr_o = instr_reg;

    icache_tag_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_ram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (req_idx),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .wr_en_i    (refill_last),
        .wr_idx_i   (ref_idx),
        .wr_tag_i   (ref_tag),
        .clr_i      (flush_i)
    );

    // Data array write port: one word per memory beat during refill
    always_ff @(posedge clk_i) begin
        if (refill_beat) begin
            data_mem[{ref_idx, cnt_reg}] <= mem_data_i;
        end
    end

    // Control FSM plus registered hit read and refill replay of the requested word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pc_reg    <= '0;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            crit_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    valid_reg <= hit;
                    if (hit) begin
                        instr_reg <= data_mem[req_wa[OFF_W+IDX_W-1:0]];
                    end else if (icache_rd_i) begin
                        pc_reg    <= req_wa;
                        cnt_reg   <= '0;
                        state_reg <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    valid_reg <= 1'b0;
                    if (mem_valid_i) begin
                        cnt_reg <= cnt_reg + OFF_W'(1);
                        // Keep the requested word as it streams past
                        if (cnt_reg == pc_reg[OFF_W-1:0]) begin
                            crit_reg <= mem_data_i;
                        end
                        if (cnt_reg == '1) begin
                            valid_reg <= 1'b1;
                            instr_reg <= (cnt_reg == pc_reg[OFF_W-1:0]) ? mem_data_i : crit_reg;
                            state_reg <= ST_RESPOND;
                        end
                    end
                end
                ST_RESPOND: begin
                    valid_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios followed by random
// reads, checked against a line-level model of a 16x4 direct-mapped cache.
module tb_icache_dm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        icache_rd_i = 1'b0;
    logic [15:0] icache_pc_i = '0;
    logic        icache_valid_o;
    logic [15:0] icache_instr_o;
    logic        flush_i = 1'b0;
    logic        mem_rd_o;
    logic [15:0] mem_addr_o;
    logic        mem_valid_i;
    logic [15:0] mem_data_i;

    logic        mem_valid_m = 1'b0;
    logic [15:0] mem_data_m  = '0;
    logic        stray       = 1'b0;
    logic        pend        = 1'b0;
    logic [15:0] pend_addr   = '0;
    int          age         = 0;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] acks[$];
    bit          m_valid [16];
    int          m_tag   [16];

    assign mem_valid_i = mem_valid_m | stray;
    assign mem_data_i  = mem_data_m;

    icache_dm dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .icache_rd_i    (icache_rd_i),
        .icache_pc_i    (icache_pc_i),
        .icache_valid_o (icache_valid_o),
        .icache_instr_o (icache_instr_o),
        .flush_i        (flush_i),
        .mem_rd_o       (mem_rd_o),
        .mem_addr_o     (mem_addr_o),
        .mem_valid_i    (mem_valid_i),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory: data = addr ^ A5A5, valid two cycles after a new address appears
    always @(negedge clk_i) begin
        if (mem_rd_o) begin
            if (!pend || mem_addr_o != pend_addr) begin
                pend      = 1'b1;
                pend_addr = mem_addr_o;
                age       = 0;
            end else begin
                age = age + 1;
            end
            mem_valid_m = (age == 2);
            mem_data_m  = mem_addr_o ^ 16'hA5A5;
        end else begin
            pend        = 1'b0;
            mem_valid_m = 1'b0;
        end
    end

    // Log each word actually accepted by the cache
    always @(posedge clk_i) begin
        if (!rst_i && mem_rd_o && mem_valid_i) acks.push_back(mem_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    // One fetch: hold the request until valid, then one idle cycle
    task automatic do_read(input logic [15:0] pc, input bit flush_rd, input bit flush_mid);
        int          idx, tag, n, exp_lat;
        bit          hit;
        logic [15:0] exp_data, base, held;
        idx      = (pc >> 3) % 16;
        tag      = pc >> 7;
        base     = pc & 16'hFFF8;
        exp_data = (pc & 16'hFFFE) ^ 16'hA5A5;
        if (flush_rd) model_clear();
        hit     = m_valid[idx] && (m_tag[idx] == tag);
        exp_lat = hit ? 1 : 13;
        if (!hit) begin
            if (flush_mid) model_clear();
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
        acks.delete();
        icache_rd_i = 1'b1;
        icache_pc_i = pc;
        flush_i     = flush_rd;
        n = 0;
        while (1) begin
            @(posedge clk_i); #1;
            flush_i = 1'b0;
            n++;
            if (flush_mid && n == 5) flush_i = 1'b1;
            if (icache_valid_o || n > 40) break;
        end
        flush_i = 1'b0;
        $display("read pc=%h hit=%0d lat=%0d instr=%h acks=%0d", pc, hit, n, icache_instr_o, acks.size());
        check("latency", n, exp_lat);
        check("instr", icache_instr_o, exp_data);
        check("mem_words", acks.size(), hit ? 0 : 4);
        if (!hit && acks.size() == 4) begin
            for (int i = 0; i < 4; i++) check("mem_addr", acks[i], base + 16'(2 * i));
        end
        held = icache_instr_o;
        icache_rd_i = 1'b0;
        @(posedge clk_i); #1;
        check("gap_valid", icache_valid_o, 1'b0);
        check("gap_instr", icache_instr_o, held);
    endtask

    initial begin
        int          n;
        logic [15:0] pc;
        model_clear();
        #1;
        check("rst_valid", icache_valid_o, 1'b0);
        check("rst_instr", icache_instr_o, 16'h0);
        check("rst_memrd", mem_rd_o, 1'b0);
        check("rst_addr", mem_addr_o, 16'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // 1-3: cold miss, hit, conflict, conflict back
        do_read(16'h0014, 0, 0);
        do_read(16'h0016, 0, 0);
        do_read(16'h0094, 0, 0);
        do_read(16'h0014, 0, 0);
        do_read(16'hFFFE, 0, 0);
        do_read(16'hFFFB, 0, 0);

        // 4: flush in IDLE, then flush mid-refill, then re-read hits
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        model_clear();
        do_read(16'h0016, 0, 0);
        do_read(16'h0094, 0, 1);
        do_read(16'h0092, 0, 0);
        do_read(16'h0010, 1, 0);

        // 5: reset during the second refill word
        icache_rd_i = 1'b1;
        icache_pc_i = 16'h0234;
        acks.delete();
        n = 0;
        while (acks.size() < 1 && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("rst_wait", acks.size(), 1);
        #2 rst_i = 1'b1;
        icache_rd_i = 1'b0;
        #1;
        check("arst_valid", icache_valid_o, 1'b0);
        check("arst_instr", icache_instr_o, 16'h0);
        check("arst_memrd", mem_rd_o, 1'b0);
        check("arst_addr", mem_addr_o, 16'h0);
        model_clear();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        stray = 1'b1;
        @(posedge clk_i); #1;
        stray = 1'b0;
        check("stray_memrd", mem_rd_o, 1'b0);
        check("stray_valid", icache_valid_o, 1'b0);
        do_read(16'h0014, 0, 0);

        // 6: back-to-back hits across one line, then a gap
        do_read(16'h0016, 0, 0);
        icache_rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 16'h0010 + 16'(2 * i);
            icache_pc_i = pc;
            @(posedge clk_i); #1;
            $display("b2b pc=%h valid=%0d instr=%h", pc, icache_valid_o, icache_instr_o);
            check("b2b_valid", icache_valid_o, 1'b1);
            check("b2b_instr", icache_instr_o, pc ^ 16'hA5A5);
        end
        icache_rd_i = 1'b0;
        @(posedge clk_i); #1;
        check("b2b_gap_valid", icache_valid_o, 1'b0);
        check("b2b_gap_instr", icache_instr_o, 16'h0016 ^ 16'hA5A5);

        // Random reads over a small footprint to mix hits and conflicts
        for (int i = 0; i < 50; i++) begin
            pc = 16'(($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 3) |
                     ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            do_read(pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
